sprite_addr_calc: RTL and testbench
===================================

Name: sprite_addr_calc

Overview:
Per-pixel sprite address generator for the tile/sprite display pipeline.
- Given the current raster position (hcount, vcount), a pattern descriptor and a sprite instance descriptor, it decides whether the pixel falls inside the sprite.
- If it does, it produces the sprite-ROM address of the colour index to fetch.
- Each display component (e.g. the fireball display) instantiates one per ping/pong buffer and indexes its palette ROM with the result.

Parameters:
- ADDR_W, 16, width of addr_output.
- MAX_SHIFT, 3, largest supported power-of-two upscale exponent (act = res << k, k in 0..MAX_SHIFT).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pattern_info  in  80  [79:64] base (append) address, [63:48] res_h, [47:32] res_v, [31:16] act_h, [15:0] act_v
- sprite_info  in  32  [31] visible, [30] flip_h, [29:20] x, [19:10] y, [9:0] attribute (ignored)
- hcount  in  10  current pixel column
- vcount  in  10  current pixel row
- addr_output  out  ADDR_W  sprite-ROM address
- valid  out  1  pixel lies inside a visible sprite

Behaviour:
- Reset (reset=0, asynchronous): addr_output=0, valid=0, held while reset is low. Normal operation resumes on the first clk edge after release.
- Outputs are registered with 1-cycle latency: the values present after posedge N reflect the inputs sampled at posedge N.
- Offsets: dx = hcount − x and dy = vcount − y, both unsigned 10-bit.
- Inside test, all evaluated unsigned with no wrap:
  - hcount >= x and vcount >= y,
  - dx < act_h and dy < act_v, compared at 16 bits.
- Scale exponent per axis: k_h is the smallest k in 0..MAX_SHIFT with (res_h << k) == act_h; k_v is derived the same way from res_v and act_v.
- valid = visible & inside & k_h found & k_v found & res_h != 0 & res_v != 0.
- Source coordinates: col0 = dx >> k_h, row = dy >> k_v.
- Horizontal flip: col = flip_h ? (res_h − 1 − col0) : col0. Vertical flip is not supported.
- Address: addr_output = append + row*res_h + col, truncated to ADDR_W (wraps mod 2^16).
- When valid=0, addr_output still carries the computed value, which is don't-care to consumers. Consumers must gate on valid.
- Unsupported ratio (act not equal to res<<k for any k): valid=0.
- act_h=0 or act_v=0: valid=0.
- attribute bits [9:0] have no effect.
- Inputs may change every cycle. There is no handshake and no internal state beyond the output registers.

Decomposition:
- Package sprite_pkg holds:
  - typedef struct packed pattern_info_t {append, res_h, res_v, act_h, act_v}, each 16 bits;
  - typedef struct packed sprite_info_t {visible, flip_h, x[9:0], y[9:0], attr[9:0]};
  - the field bit-position constants and ADDR_W.
- One natural sub-module, sprite_axis_map, instantiated twice (horizontal, vertical):
  - inputs: pos, origin, res, act;
  - outputs: in_range, scaled coordinate, ratio_ok.
- Flip, multiply-add and output registers live in the top.

Test Plan:
- Reset: hold reset=0, toggle inputs → addr_output=0, valid=0 throughout. First edge after release with pattern {0,64,64,64,64}, sprite visible, x=100, y=50, hcount=100, vcount=50 → valid=1, addr_output=0.
- Bounds, same setup:
  - hcount=163, vcount=113 → addr 4095, valid=1;
  - hcount=164 or vcount=114 or hcount=99 → valid=0.
- Flip: flip_h=1, hcount=100, vcount=50 → addr 63. hcount=163, vcount=51 → addr 64.
- Scaling: pattern {0x100,16,16,32,32}, x=0, y=0, hcount=5, vcount=3 → col 2, row 1, addr 0x112, valid=1.
- Invalid cases:
  - visible=0 → valid=0;
  - pattern {0,16,16,24,16} (unsupported ratio) → valid=0;
  - act_v=0 → valid=0.
- Latency: change hcount every cycle across x=100..103 → addr_output sequence 0,1,2,3, each one cycle after the input.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and field positions for the sprite address pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sprite_pkg;

    localparam int ADDR_W    = 16;
    localparam int MAX_SHIFT = 3;
    localparam int FIELD_W   = 16;
    localparam int COORD_W   = 10;

    // Bit positions inside the flat 80-bit pattern descriptor
    localparam int PI_APPEND_LSB = 64;
    localparam int PI_RES_H_LSB  = 48;
    localparam int PI_RES_V_LSB  = 32;
    localparam int PI_ACT_H_LSB  = 16;
    localparam int PI_ACT_V_LSB  = 0;

    // Bit positions inside the flat 32-bit sprite instance descriptor
    localparam int SI_VISIBLE_BIT = 31;
    localparam int SI_FLIP_H_BIT  = 30;
    localparam int SI_X_LSB       = 20;
    localparam int SI_Y_LSB       = 10;
    localparam int SI_ATTR_LSB    = 0;

    typedef struct packed {
        logic [FIELD_W-1:0] append;
        logic [FIELD_W-1:0] res_h;
        logic [FIELD_W-1:0] res_v;
        logic [FIELD_W-1:0] act_h;
        logic [FIELD_W-1:0] act_v;
    } pattern_info_t;

    typedef struct packed {
        logic               visible;
        logic               flip_h;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] attr;
    } sprite_info_t;

endpackage

// File: rtl/sprite_axis_map.sv
// One axis of the sprite mapping: range test, scale exponent and source coordinate.
// Latency: purely combinational.
// Backpressure: none.
module sprite_axis_map
    import sprite_pkg::*;
#(
    parameter int MAX_SHIFT = sprite_pkg::MAX_SHIFT
) (
    input  logic [COORD_W-1:0] pos_i,
    input  logic [COORD_W-1:0] origin_i,
    input  logic [FIELD_W-1:0] res_i,
    input  logic [FIELD_W-1:0] act_i,
    output logic               in_range_o,
    output logic [FIELD_W-1:0] coord_o,
    output logic               ratio_ok_o
);

    localparam int SHW = (MAX_SHIFT > 0) ? $clog2(MAX_SHIFT + 1) : 1;
    localparam int EXW = FIELD_W + MAX_SHIFT;

    logic [COORD_W-1:0] delta;
    logic [EXW-1:0]     res_ext;
    logic [EXW-1:0]     act_ext;
    logic [SHW-1:0]     shamt;
    logic               found;

    // Offset, range test and smallest power-of-two exponent mapping res onto act.
    // Shifts are done at extended width so a large res cannot wrap into a false match.
    always_comb begin
        delta   = pos_i - origin_i;
        res_ext = {{MAX_SHIFT{1'b0}}, res_i};
        act_ext = {{MAX_SHIFT{1'b0}}, act_i};
        found   = 1'b0;
        shamt   = '0;
        // Descending scan: the last hit is the smallest exponent.
        for (int k = MAX_SHIFT; k >= 0; k--) begin
            if ((res_ext << k) == act_ext) begin
                found = 1'b1;
                shamt = SHW'(k);
            end
        end
        in_range_o = (pos_i >= origin_i) &&
                     ({{(FIELD_W-COORD_W){1'b0}}, delta} < act_i);
        coord_o    = {{(FIELD_W-COORD_W){1'b0}}, delta} >> shamt;
        ratio_ok_o = found && (res_i != '0);
    end

endmodule

// File: rtl/sprite_addr_calc.sv
// Per-pixel sprite hit test and sprite-ROM address generation.
// Latency: 1 cycle, registered outputs.
// Backpressure: none; new inputs accepted every cycle.
module sprite_addr_calc
    import sprite_pkg::*;
#(
    parameter int ADDR_W    = sprite_pkg::ADDR_W,
    parameter int MAX_SHIFT = sprite_pkg::MAX_SHIFT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [79:0]         pattern_info,
    input  logic [31:0]         sprite_info,
    input  logic [COORD_W-1:0]  hcount,
    input  logic [COORD_W-1:0]  vcount,
    output logic [ADDR_W-1:0]   addr_output,
    output logic                valid
);

    pattern_info_t      pat;
    sprite_info_t       spr;

    logic               in_h, in_v;
    logic               ok_h, ok_v;
    logic [FIELD_W-1:0] col0, row, col;
    logic [31:0]        mul_full;
    logic [31:0]        sum_full;

    logic [ADDR_W-1:0]  addr_d, addr_q;
    logic               valid_d, valid_q;
    logic               unused_bits;

    assign pat = pattern_info;
    assign spr = sprite_info;

    sprite_axis_map #(.MAX_SHIFT(MAX_SHIFT)) u_axis_h (
        .pos_i      (hcount),
        .origin_i   (spr.x),
        .res_i      (pat.res_h),
        .act_i      (pat.act_h),
        .in_range_o (in_h),
        .coord_o    (col0),
        .ratio_ok_o (ok_h)
    );

    sprite_axis_map #(.MAX_SHIFT(MAX_SHIFT)) u_axis_v (
        .pos_i      (vcount),
        .origin_i   (spr.y),
        .res_i      (pat.res_v),
        .act_i      (pat.act_v),
        .in_range_o (in_v),
        .coord_o    (row),
        .ratio_ok_o (ok_v)
    );

    // Mirror the column, then row-major address into the pattern, wrapping at ADDR_W.
    always_comb begin
        col      = spr.flip_h ? (pat.res_h - 16'd1 - col0) : col0;
        mul_full = {16'd0, row} * {16'd0, pat.res_h};
        sum_full = {16'd0, pat.append} + mul_full + {16'd0, col};
        addr_d   = sum_full[ADDR_W-1:0];
        valid_d  = spr.visible & in_h & in_v & ok_h & ok_v;
    end

    // Attribute bits are carried in the descriptor but do not affect addressing.
    assign unused_bits = ^{spr.attr, sum_full[31:ADDR_W]};

    // Output registers; cleared asynchronously while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    assign addr_output = addr_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_sprite_addr_calc.sv
// Directed bench for sprite_addr_calc with hand-computed expectations.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_sprite_addr_calc;
    import sprite_pkg::*;

    logic        clk;
    logic        reset;
    logic [79:0] pattern_info;
    logic [31:0] sprite_info;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [15:0] addr_output;
    logic        valid;

    int n_assert = 0;
    int n_fail   = 0;

    sprite_addr_calc dut (
        .clk          (clk),
        .reset        (reset),
        .pattern_info (pattern_info),
        .sprite_info  (sprite_info),
        .hcount       (hcount),
        .vcount       (vcount),
        .addr_output  (addr_output),
        .valid        (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [79:0] pat(input logic [15:0] a, rh, rv, ah, av);
        logic [79:0] p;
        p = '0;
        p[PI_APPEND_LSB +: 16] = a;
        p[PI_RES_H_LSB  +: 16] = rh;
        p[PI_RES_V_LSB  +: 16] = rv;
        p[PI_ACT_H_LSB  +: 16] = ah;
        p[PI_ACT_V_LSB  +: 16] = av;
        return p;
    endfunction

    function automatic logic [31:0] spr(input logic vis, flip,
                                        input logic [9:0] x, y, attr);
        logic [31:0] s;
        s = '0;
        s[SI_VISIBLE_BIT]   = vis;
        s[SI_FLIP_H_BIT]    = flip;
        s[SI_X_LSB +: 10]   = x;
        s[SI_Y_LSB +: 10]   = y;
        s[SI_ATTR_LSB +: 10] = attr;
        return s;
    endfunction

    task automatic chk_v(input string tag, input logic exp);
        n_assert++;
        assert (valid === exp) else begin
            n_fail++;
            $error("FAIL %s valid: observed %b expected %b", tag, valid, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [15:0] exp);
        n_assert++;
        assert (addr_output === exp) else begin
            n_fail++;
            $error("FAIL %s addr: observed %h expected %h", tag, addr_output, exp);
        end
    endtask

    // Present a raster position, clock it in and sample just after the edge.
    task automatic step(input logic [9:0] h, v);
        hcount = h;
        vcount = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b0;
        pattern_info = pat(16'd0, 16'd64, 16'd64, 16'd64, 16'd64);
        sprite_info  = spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0);
        hcount       = 10'd100;
        vcount       = 10'd50;

        // Reset held: outputs stay clear while inputs move.
        for (int i = 0; i < 4; i++) begin
            step(10'd100 + 10'(i), 10'd50);
            chk_v("reset", 1'b0);
            chk_a("reset", 16'h0000);
        end

        // Release between edges; first edge loads the in-sprite origin.
        #2 reset = 1'b1;
        step(10'd100, 10'd50);
        chk_v("first", 1'b1);
        chk_a("first", 16'd0);

        // Bounds
        step(10'd163, 10'd113);
        chk_v("corner", 1'b1);
        chk_a("corner", 16'd4095);
        step(10'd164, 10'd60);
        chk_v("h_past", 1'b0);
        step(10'd120, 10'd114);
        chk_v("v_past", 1'b0);
        step(10'd99, 10'd60);
        chk_v("h_before", 1'b0);
        step(10'd120, 10'd49);
        chk_v("v_before", 1'b0);

        // Asynchronous reset mid-run clears immediately
        step(10'd101, 10'd51);
        chk_a("pre_arst", 16'd65);
        #2 reset = 1'b0;
        #1;
        chk_v("arst", 1'b0);
        chk_a("arst", 16'd0);
        reset = 1'b1;

        // Horizontal flip
        sprite_info = spr(1'b1, 1'b1, 10'd100, 10'd50, 10'd0);
        step(10'd100, 10'd50);
        chk_v("flip0", 1'b1);
        chk_a("flip0", 16'd63);
        step(10'd163, 10'd51);
        chk_a("flip1", 16'd64);

        // 2x scaling with base offset
        pattern_info = pat(16'h0100, 16'd16, 16'd16, 16'd32, 16'd32);
        sprite_info  = spr(1'b1, 1'b0, 10'd0, 10'd0, 10'd0);
        step(10'd5, 10'd3);
        chk_v("scale2", 1'b1);
        chk_a("scale2", 16'h0112);

        // Attribute bits do not matter
        sprite_info = spr(1'b1, 1'b0, 10'd0, 10'd0, 10'h3FF);
        step(10'd5, 10'd3);
        chk_v("attr", 1'b1);
        chk_a("attr", 16'h0112);

        // Largest exponent (8x) on h, 1x on v: col 21>>3=2, row 3, addr 0x20+3*8+2
        pattern_info = pat(16'h0020, 16'd8, 16'd4, 16'd64, 16'd4);
        step(10'd21, 10'd3);
        chk_v("scale8", 1'b1);
        chk_a("scale8", 16'h003A);

        // 16x exceeds the supported range
        pattern_info = pat(16'h0000, 16'd8, 16'd8, 16'd128, 16'd8);
        step(10'd1, 10'd1);
        chk_v("scale16", 1'b0);

        // Address wraps at 16 bits: 0xFFFF + 0*4 + 1
        pattern_info = pat(16'hFFFF, 16'd4, 16'd4, 16'd4, 16'd4);
        step(10'd1, 10'd0);
        chk_v("wrap", 1'b1);
        chk_a("wrap", 16'h0000);

        // Invalid cases
        pattern_info = pat(16'd0, 16'd16, 16'd16, 16'd32, 16'd32);
        sprite_info  = spr(1'b0, 1'b0, 10'd0, 10'd0, 10'd0);
        step(10'd5, 10'd3);
        chk_v("invisible", 1'b0);
        sprite_info  = spr(1'b1, 1'b0, 10'd0, 10'd0, 10'd0);
        pattern_info = pat(16'd0, 16'd16, 16'd16, 16'd24, 16'd16);
        step(10'd5, 10'd3);
        chk_v("ratio", 1'b0);
        pattern_info = pat(16'd0, 16'd16, 16'd16, 16'd16, 16'd0);
        step(10'd5, 10'd0);
        chk_v("act_v0", 1'b0);
        pattern_info = pat(16'd0, 16'd0, 16'd16, 16'd0, 16'd16);
        step(10'd0, 10'd3);
        chk_v("res_h0", 1'b0);

        // Latency: new input between edges does not show until the next edge
        pattern_info = pat(16'd0, 16'd64, 16'd64, 16'd64, 16'd64);
        sprite_info  = spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0);
        step(10'd100, 10'd50);
        chk_a("lat0", 16'd0);
        for (int i = 1; i < 4; i++) begin
            hcount = 10'd100 + 10'(i);
            #2;
            chk_a("lat_hold", 16'(i - 1));
            @(posedge clk);
            #1;
            chk_a("lat_step", 16'(i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
